instr_fetch_queue: RTL and testbench

Prefetching instruction-fetch stage that sits directly upstream of the single-cycle MIPS core's decode/execute path. It issues word fetches to an instruction memory with a variable-latency, in-order request/response protocol. It buffers returned words together with their PCs in a small FIFO and presents them to the core over a valid/ready handshake. On a taken branch the core's redirect flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/instr_fetch_queue_if.sv | 27 ++
 rtl/instr_fetch_queue.sv | 97 +++++++++
 tb/tb_instr_fetch_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, branch redirect,
// and the valid/ready instruction handshake towards the core.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // The fetch queue itself.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  // Memory plus core side of the bus.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetching instruction-fetch queue. Issues in-order word fetches under a
// credit limit (buffered + in-flight <= DEPTH), stores returned words with
// their PCs and hands them to the core over valid/ready. A redirect flushes
// the buffer, marks outstanding responses for discard and restarts fetch.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          xfer;
  logic          keep;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [CW-1:0] rvalid_w;

  // A request is only allowed if a buffer slot is guaranteed for its response;
  // reset gates it so the request drops immediately on async reset.
  assign occupancy       = {1'b0, count} + {1'b0, inflight};
  assign bus.imem_req    = reset & ~bus.redirect & (occupancy < DEPTH_C);
  assign bus.imem_addr   = fetch_pc;
  assign xfer            = bus.imem_req & bus.imem_gnt;
  assign keep            = bus.imem_rvalid & (drop == '0) & ~bus.redirect;
  assign pop             = bus.instr_valid & bus.instr_ready & ~bus.redirect;
  assign rvalid_w        = CW'(bus.imem_rvalid);

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = word_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

  // Fetch/response PCs, credit counters and FIFO pointers; redirect wins over all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect) begin
      // No request is issued in a redirect cycle, so only a response can change inflight.
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      resp_pc  <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= inflight - rvalid_w;
      drop     <= inflight - rvalid_w;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (xfer) fetch_pc <= fetch_pc + 32'd4;
      if (keep) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (bus.imem_rvalid && drop != '0) drop <= drop - CW'(1);
      inflight <= inflight + CW'(xfer) - rvalid_w;
      count    <= count + CW'(keep) - CW'(pop);
    end
  end

  // Buffer storage: kept responses land at the write pointer with their PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (keep) begin
      word_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (!reset)
                   !(bus.imem_rvalid && inflight == '0))
    else $error("imem_rvalid with no request in flight");

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue: a memory model with
// random in-order latency, a PC-sequence reference model, and a monitor that
// checks every consumed instruction against the expected stream.
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;
  int          cyc = 0;
  int          grants = 0;
  int          npops = 0;
  int          first_grant = -1;
  int          first_valid = -1;
  logic [31:0] model_pc = RESET_PC;
  logic        prev_redirect = 1'b0;
  logic        track_sustain = 1'b0;

  // stimulus knobs
  int          gnt_mode  = 0;   // 0 always, 1 toggle, 2 random, 3 never
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;
  int          redir_pct = 0;
  logic        do_redirect = 1'b0;
  logic [31:0] redir_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle of memory + core stimulus, with reference-model update.
  task automatic step();
    logic xfer;
    int   due;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    case (gnt_mode)
      0:       bus.imem_gnt = 1'b1;
      1:       bus.imem_gnt = ((cyc % 2) == 1);
      2:       bus.imem_gnt = $urandom_range(1, 0) == 1;
      default: bus.imem_gnt = 1'b0;
    endcase
    bus.instr_ready = ($urandom_range(99, 0) < ready_pct);
    if (redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
      do_redirect = 1'b1;
      redir_pc    = $urandom & 32'h0000_3FFF;
    end
    bus.redirect    = do_redirect;
    bus.redirect_pc = do_redirect ? redir_pc : $urandom;
    do_redirect     = 1'b0;
    #1;
    if (prev_redirect) chk("valid_after_redirect", bus.instr_valid, 1'b0);
    if (track_sustain && first_valid >= 0 && cyc > first_valid)
      chk("sustained_valid", bus.instr_valid, 1'b1);
    if (bus.redirect) begin
      chk("req_in_redirect", bus.imem_req, 1'b0);
      exp_q.delete();
      model_pc = bus.redirect_pc & ~32'h3;
    end
    prev_redirect = bus.redirect;
    xfer = bus.imem_req & bus.imem_gnt;
    if (xfer) begin
      chk("fetch_addr", bus.imem_addr, model_pc);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(bus.imem_addr);
      mq_due.push_back(due);
      e.pc   = model_pc;
      e.word = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
      grants++;
      if (first_grant < 0) first_grant = cyc;
      chk("inflight_bound", mq_due.size() <= DEPTH, 1'b1);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.instr_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (bus.instr_ready && !bus.redirect) begin
        npops++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual_pc=%h required=none (cycle %0d)", bus.instr_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, e.pc);
          chk("instr", bus.instr, e.word);
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    mq_addr.delete();
    mq_due.delete();
    last_due      = 0;
    model_pc      = RESET_PC;
    prev_redirect = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b0;
  endtask

  initial begin
    int g0;
    int p0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;

    // Power-on reset values.
    #2;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1-cycle memory, always granted, core always ready.
    gnt_mode = 0; lat_min = 1; lat_max = 1; ready_pct = 100;
    track_sustain = 1'b1;
    steps(40);
    track_sustain = 1'b0;
    chk("first_valid_latency", first_valid - first_grant, 32'd2);

    // Async reset mid-stream, between clock edges.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_req", bus.imem_req, 1'b0);
    chk("midrst_valid", bus.instr_valid, 1'b0);
    clear_model();
    ready_pct = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Core stalled: exactly DEPTH grants, then requests stop.
    g0 = grants;
    steps(10);
    chk("grants_when_stalled", grants - g0, DEPTH);
    chk("req_when_full", bus.imem_req, 1'b0);
    chk("valid_when_full", bus.instr_valid, 1'b1);
    p0 = npops;
    g0 = grants;
    ready_pct = 100;
    step();
    ready_pct = 0;
    steps(6);
    chk("grants_after_one_pop", grants - g0, 32'd1);
    gnt_mode = 3; ready_pct = 100;
    steps(10);
    chk("pops_after_stall", npops - p0, 32'd5);

    // 3-cycle memory, redirect to 0x100 with a response arriving.
    gnt_mode = 0; lat_min = 3; lat_max = 3;
    steps(3);
    do_redirect = 1'b1; redir_pc = 32'h0000_0100;
    step();
    steps(15);

    // Redirect with pop and response in the same cycle, unaligned target.
    lat_min = 1; lat_max = 1;
    steps(6);
    do_redirect = 1'b1; redir_pc = 32'h0000_0203;
    step();
    steps(10);

    // Toggling grant, then random grant, random latency and redirects.
    gnt_mode = 1; lat_min = 1; lat_max = 5; ready_pct = 70; redir_pct = 3;
    steps(300);
    gnt_mode = 2;
    steps(300);
    redir_pct = 0;

    // Drain: everything granted must have been delivered exactly once.
    gnt_mode = 3; ready_pct = 100;
    steps(40);
    chk("drain_expected_left", exp_q.size(), 32'd0);
    chk("drain_mem_outstanding", mq_due.size(), 32'd0);
    chk("drain_valid", bus.instr_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
